// File: rtl/dtg_pkg.sv
// rtl/dtg_pkg.sv - display timing generator mode constants, FSM states and sync helper
package dtg_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } dtg_mode_t;

    localparam dtg_mode_t MODE_640X480  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam dtg_mode_t MODE_800X600  = '{800, 40, 128, 88, 600, 1, 4, 23};
    localparam dtg_mode_t MODE_1024X768 = '{1024, 24, 136, 144, 768, 3, 6, 29};

    typedef logic [1:0] dtg_state_t;

    localparam dtg_state_t ST_IDLE  = 2'd0;
    localparam dtg_state_t ST_RUN   = 2'd1;
    localparam dtg_state_t ST_DRAIN = 2'd2;

    // Pin level for a sync that is (or is not) inside its window.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/dtg_axis_cnt.sv
// rtl/dtg_axis_cnt.sv - enabled wrap counter with a wrap pulse, one per display axis
module dtg_axis_cnt #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] wrap_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == wrap_val);

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dtg_param.sv
// rtl/dtg_param.sv - parametrised display timing generator; DTG_FRAME_CNT_EN adds frame_count
module dtg_param
    import dtg_pkg::*;
#(
    parameter int H_ACTIVE  = MODE_800X600.h_active,
    parameter int H_FP      = MODE_800X600.h_fp,
    parameter int H_SYNC    = MODE_800X600.h_sync,
    parameter int H_BP      = MODE_800X600.h_bp,
    parameter int V_ACTIVE  = MODE_800X600.v_active,
    parameter int V_FP      = MODE_800X600.v_fp,
    parameter int V_SYNC    = MODE_800X600.v_sync,
    parameter int V_BP      = MODE_800X600.v_bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 12
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          run,
    output logic          horiz_sync,
    output logic          vert_sync,
    output logic          video_on,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic [31:0]   pix_num,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
`ifdef DTG_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    dtg_state_t    state;
    dtg_state_t    state_nx;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          adv;
    logic          h_wrap;
    logic          v_wrap;
    logic          to_idle;
    logic          frame_hit;
    logic          h_act;
    logic          v_act;
    logic          h_in_sync;
    logic          v_in_sync;
    logic [31:0]   pix_next;

    // v_wrap is only raised on the h wrap of the last line, i.e. the full-frame wrap.
    assign adv       = pix_ce && (state != ST_IDLE);
    assign to_idle   = (state == ST_DRAIN) && !run && v_wrap;
    assign frame_hit = adv && !to_idle && (h_cnt == '0) && (v_cnt == '0);
    assign busy      = (state != ST_IDLE);

    assign h_act     = (h_cnt < H_ACT);
    assign v_act     = (v_cnt < V_ACT);
    assign h_in_sync = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign v_in_sync = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    dtg_axis_cnt #(.W(CW)) u_h_cnt (
        .clock    (clock),
        .rst      (rst),
        .en       (adv),
        .wrap_val (H_LAST),
        .cnt      (h_cnt),
        .wrap     (h_wrap)
    );

    dtg_axis_cnt #(.W(CW)) u_v_cnt (
        .clock    (clock),
        .rst      (rst),
        .en       (h_wrap),
        .wrap_val (V_LAST),
        .cnt      (v_cnt),
        .wrap     (v_wrap)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (run) state_nx = ST_RUN;
            ST_RUN:   if (!run) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (run) begin
                    state_nx = ST_RUN;
                end else if (v_wrap) begin
                    state_nx = ST_IDLE;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs describe the pixel at the pre-advance counters, so they trail h_cnt/v_cnt by one.
    always_ff @(posedge clock) begin
        if (rst || to_idle) begin
            horiz_sync   <= ~HSYNC_POL;
            vert_sync    <= ~VSYNC_POL;
            video_on     <= 1'b0;
            pixel_column <= '0;
            pixel_row    <= '0;
            pix_num      <= '0;
            pix_next     <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (adv) begin
            horiz_sync   <= sync_level(h_in_sync, HSYNC_POL);
            vert_sync    <= sync_level(v_in_sync, VSYNC_POL);
            video_on     <= h_act && v_act;
            pixel_column <= h_cnt;
            pixel_row    <= v_cnt;
            line_start   <= (h_cnt == '0);
            frame_start  <= frame_hit;
            // pix_next is the index of the next active pixel; it restarts during vertical blanking.
            if (!v_act) begin
                pix_num  <= '0;
                pix_next <= '0;
            end else if (h_act) begin
                pix_num  <= pix_next;
                pix_next <= pix_next + 32'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef DTG_FRAME_CNT_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_hit) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtg_param.sv
// tb/tb_dtg_param.sv - randomized self-checking bench for dtg_param against a position-based frame model
module tb_dtg_param;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;
    logic run = 1'b0;

    logic        hs0, vs0, von0, ls0, fs0, busy0;
    logic [11:0] col0, row0;
    logic [31:0] pn0;
    logic        hs1, vs1, von1, ls1, fs1, busy1;
    logic [11:0] col1, row1;
    logic [31:0] pn1;
`ifdef DTG_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    dtg_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) dut (
        .clock(clock), .rst(rst), .pix_ce(pix_ce), .run(run),
        .horiz_sync(hs0), .vert_sync(vs0), .video_on(von0),
        .pixel_column(col0), .pixel_row(row0), .pix_num(pn0),
        .line_start(ls0), .frame_start(fs0), .busy(busy0)
`ifdef DTG_FRAME_CNT_EN
        , .frame_count(fc0)
`endif
    );

    dtg_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(12)
    ) dut_p (
        .clock(clock), .rst(rst), .pix_ce(pix_ce), .run(run),
        .horiz_sync(hs1), .vert_sync(vs1), .video_on(von1),
        .pixel_column(col1), .pixel_row(row1), .pix_num(pn1),
        .line_start(ls1), .frame_start(fs1), .busy(busy1)
`ifdef DTG_FRAME_CNT_EN
        , .frame_count(fc1)
`endif
    );

    // Reference model: a frame is FRAME consecutive pixel positions; outputs follow from the position.
    int m_pos = 0;
    bit m_gen = 0;
    bit m_dr = 0;
    int m_fc = 0;
    int e_col = 0, e_row = 0, e_pn = 0;
    bit e_hs = 0, e_vs = 0, e_von = 0, e_ls = 0, e_fs = 0, e_busy = 0;

    always @(posedge clock) begin
        e_ls = 0;
        e_fs = 0;
        if (rst || (m_gen && m_dr && !run && pix_ce && m_pos == FRAME - 1)) begin
            if (rst) m_fc = 0;
            m_gen = 0; m_dr = 0; m_pos = 0;
            e_col = 0; e_row = 0; e_pn = 0; e_hs = 0; e_vs = 0; e_von = 0;
        end else if (!m_gen) begin
            if (run) m_gen = 1;
        end else begin
            if (pix_ce) begin
                e_col = m_pos % HT;
                e_row = m_pos / HT;
                e_hs  = (e_col >= HA + HFP) && (e_col < HA + HFP + HS);
                e_vs  = (e_row >= VA + VFP) && (e_row < VA + VFP + VS);
                e_von = (e_col < HA) && (e_row < VA);
                e_pn  = (e_row < VA) ? e_row * HA + ((e_col < HA) ? e_col : HA - 1) : 0;
                e_ls  = (e_col == 0);
                e_fs  = (m_pos == 0);
                if (e_fs) m_fc = (m_fc + 1) % 65536;
                m_pos = (m_pos + 1) % FRAME;
            end
            m_dr = !run;
        end
        e_busy = m_gen;
    end

    logic [61:0] act0, act1, exp0, exp1;
    assign act0 = {hs0, vs0, von0, ls0, fs0, busy0, col0, row0, pn0};
    assign act1 = {hs1, vs1, von1, ls1, fs1, busy1, col1, row1, pn1};
    assign exp0 = {~e_hs, ~e_vs, e_von, e_ls, e_fs, e_busy, e_col[11:0], e_row[11:0], e_pn};
    assign exp1 = {e_hs, e_vs, e_von, e_ls, e_fs, e_busy, e_col[11:0], e_row[11:0], e_pn};

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_ce = 1'($urandom_range(0, 1));
            run    = 1'($urandom_range(0, 1));
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL reset_vec: dut=%h/%h model=%h/%h", act0, act1, exp0, exp1);
            end
        end
        n_chk++;
        if ({hs0, vs0, hs1, vs1, busy0, von0, pn0} !== {4'b1100, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_idle: hs0=%b vs0=%b hs1=%b vs1=%b busy=%b von=%b pn=%0d", hs0, vs0, hs1, vs1, busy0, von0, pn0);
        end
`ifdef DTG_FRAME_CNT_EN
        n_chk++;
        if (fc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_frame_count: dut=%0d expected=0", fc0);
        end
`endif
    endtask

    task automatic test_tiny_frame();
        int last_fs = -1;
        int last_ls = -1;
        rst = 1'b0; run = 1'b1; pix_ce = 1'b1;
        tick();
        n_chk++;
        if (busy0 !== 1'b1 || fs0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tiny_enter_run: busy=%b fs=%b expected busy=1 fs=0", busy0, fs0);
        end
        tick();
        n_chk++;
        if (fs0 !== 1'b1 || col0 !== 12'd0 || row0 !== 12'd0) begin
            n_fail++;
            $display("FAIL tiny_first_pixel: fs=%b col=%0d row=%0d expected fs=1 col=0 row=0", fs0, col0, row0);
        end
        last_fs = cyc;
        last_ls = cyc;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL tiny_frame: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
            if (ls0) begin
                n_chk++;
                if (cyc - last_ls !== HT) begin
                    n_fail++;
                    $display("FAIL tiny_line_period: got=%0d expected=%0d", cyc - last_ls, HT);
                end
                last_ls = cyc;
            end
            if (fs0) begin
                n_chk++;
                if (cyc - last_fs !== FRAME) begin
                    n_fail++;
                    $display("FAIL tiny_frame_period: got=%0d expected=%0d", cyc - last_fs, FRAME);
                end
                last_fs = cyc;
            end
        end
    endtask

    task automatic test_ce_gating();
        int last_ls = -1;
        run = 1'b1;
        for (int i = 0; i < 3 * FRAME + 6; i++) begin
            pix_ce = (i % 3 == 0);
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL ce_third: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
            if (ls0) begin
                if (last_ls >= 0) begin
                    n_chk++;
                    if (cyc - last_ls !== 3 * HT) begin
                        n_fail++;
                        $display("FAIL ce_line_period: got=%0d expected=%0d", cyc - last_ls, 3 * HT);
                    end
                end
                last_ls = cyc;
            end
        end
        for (int i = 0; i < 300; i++) begin
            pix_ce = 1'($urandom_range(0, 1));
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL ce_random: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
        end
    endtask

    task automatic test_drain();
        int n = 0;
        int last_fs = -1;
        bit found = 0;
        run = 1'b1; pix_ce = 1'b1;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            tick();
            if (e_row == 2 && e_col == 5) found = 1;
        end
        run = 1'b0;
        for (int i = 0; i < 2 * FRAME && busy0 !== 1'b0; i++) begin
            tick();
            n++;
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL drain_vec: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
        end
        n_chk++;
        if (!found || n !== FRAME - (2 * HT + 6)) begin
            n_fail++;
            $display("FAIL drain_length: found=%0d clocks=%0d expected=%0d", found, n, FRAME - (2 * HT + 6));
        end
        n_chk++;
        if ({busy0, hs0, vs0, hs1, vs1, col0, row0} !== {5'b01100, 24'd0}) begin
            n_fail++;
            $display("FAIL drain_idle: busy=%b hs0=%b vs0=%b hs1=%b vs1=%b col=%0d row=%0d", busy0, hs0, vs0, hs1, vs1, col0, row0);
        end
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (found && i == 40) run = 1'b1;
            else if (!found && e_row == 6 && e_col == 0) begin
                run = 1'b0;
                found = 1;
                i = 30;
            end
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL drain_resume: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
            if (fs0) begin
                if (last_fs >= 0) begin
                    n_chk++;
                    if (cyc - last_fs !== FRAME) begin
                        n_fail++;
                        $display("FAIL drain_resume_period: got=%0d expected=%0d", cyc - last_fs, FRAME);
                    end
                end
                last_fs = cyc;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        run = 1'b1; pix_ce = 1'b1;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            tick();
            if (e_row == 3 && e_col == 9) found = 1;
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (!found || {hs0, vs0, von0, busy0, ls0, fs0, col0, row0, pn0} !== {6'b110000, 56'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_idle: found=%0d dut=%h", found, act0);
        end
        n_chk++;
        if (act0 !== exp0 || act1 !== exp1) begin
            n_fail++;
            $display("FAIL reset_mid_vec: dut=%h/%h model=%h/%h", act0, act1, exp0, exp1);
        end
        rst = 1'b0;
        tick();
        tick();
        n_chk++;
        if (fs0 !== 1'b1 || col0 !== 12'd0 || row0 !== 12'd0 || von0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: fs=%b col=%0d row=%0d von=%b expected 1/0/0/1", fs0, col0, row0, von0);
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 1500; i++) begin
            pix_ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            rst = ($urandom_range(0, 499) == 0);
            tick();
            n_chk++;
            if (act0 !== exp0 || act1 !== exp1) begin
                n_fail++;
                $display("FAIL random_mix: cyc=%0d dut=%h/%h model=%h/%h", cyc, act0, act1, exp0, exp1);
            end
        end
        rst = 1'b0;
    endtask

`ifdef DTG_FRAME_CNT_EN
    task automatic test_frame_count();
        bit seen = 0;
        rst = 1'b1; run = 1'b1; pix_ce = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            tick();
            n_chk++;
            if (fc0 !== m_fc[15:0] || fc1 !== m_fc[15:0]) begin
                n_fail++;
                $display("FAIL frame_count: dut=%0d/%0d model=%0d", fc0, fc1, m_fc);
            end
        end
        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick();
            if (fs0) seen = 1;
        end
        n_chk++;
        if (!seen || fc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_count_wrap: seen=%0d dut=%h expected=0000", seen, fc0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tiny_frame();
        test_ce_gating();
        test_drain();
        test_reset_mid();
        test_random_mix();
`ifdef DTG_FRAME_CNT_EN
        test_frame_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
